// File: rtl/ad79x8_sample_collector.sv
// AD79X8 sample collector: checks each SPI frame, extracts channel/result,
// keeps the latest sample per channel in a bank and forwards enabled
// channels through a FWFT FIFO. Never stalls the SPI master; overflow drops.
module ad79x8_sample_collector #(
  parameter int DIGITS     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_valid,
  input  logic [15:0]       frame,
  input  logic [7:0]        ch_mask,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [2:0]        s_channel,
  output logic [DIGITS-1:0] s_data,
  input  logic              rd_en,
  input  logic [2:0]        rd_addr,
  output logic [DIGITS-1:0] rd_data,
  output logic [7:0]        fresh,
  output logic [7:0]        err_count,
  output logic [7:0]        ovf_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 3 + DIGITS;

  // Frame decode. Result LSBs below the converter resolution are don't-care.
  logic [2:0]        frm_ch;
  logic [DIGITS-1:0] frm_data;
  logic              good, bad;
  logic              frame_unused;

  assign frm_ch       = frame[14:12];
  assign frm_data     = frame[11 -: DIGITS];
  assign good         = frame_valid & ~frame[15];
  assign bad          = frame_valid &  frame[15];
  assign frame_unused = ^frame;

  // FIFO state
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [EW-1:0] head_q, head_d, push_word;
  logic          full, pop, push_req, push, drop;

  // Per-channel state and counters
  logic [DIGITS-1:0] bank_q [8];
  logic [DIGITS-1:0] rd_data_q, rd_data_d;
  logic [7:0]        fresh_q, fresh_d;
  logic [7:0]        err_q, err_d, ovf_q, ovf_d;

  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign s_valid   = (cnt_q != '0);
  assign pop       = s_valid & s_ready;
  assign push_req  = good & ch_mask[frm_ch];
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push      = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;
  assign push_word = {frm_ch, frm_data};

  // Next-state for FIFO pointers, occupancy, registered head, bank read, flags
  always_comb begin
    wr_ptr_d  = wr_ptr_q + AW'(push);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    head_d    = head_q;
    // Head is registered so it holds its last value once the FIFO drains.
    // If the FIFO is empty after the pop, the only possible head is the push.
    if (cnt_d != '0)
      head_d = (cnt_q == CW'(pop)) ? push_word : mem_q[rd_ptr_d];
    rd_data_d = rd_en ? bank_q[rd_addr] : rd_data_q;
    fresh_d   = fresh_q;
    if (rd_en) fresh_d[rd_addr] = 1'b0;
    // Set after clear: a write to the channel being read keeps it fresh.
    if (good)  fresh_d[frm_ch] = 1'b1;
    err_d     = (bad  && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    ovf_d     = (drop && ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;
  end

  // Control/state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      head_q    <= '0;
      rd_data_q <= '0;
      fresh_q   <= '0;
      err_q     <= '0;
      ovf_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      head_q    <= head_d;
      rd_data_q <= rd_data_d;
      fresh_q   <= fresh_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy is cleared
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= push_word;
  end

  // Latest-sample bank, written by every good frame regardless of mask
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) bank_q[i] <= '0;
    end else if (good) begin
      bank_q[frm_ch] <= frm_data;
    end
  end

  assign s_channel = head_q[EW-1 -: 3];
  assign s_data    = head_q[DIGITS-1:0];
  assign rd_data   = rd_data_q;
  assign fresh     = fresh_q;
  assign err_count = err_q;
  assign ovf_count = ovf_q;

endmodule

// File: tb/tb_ad79x8_sample_collector.sv
// Randomized + directed bench for ad79x8_sample_collector against a
// queue/array reference model.
module tb_ad79x8_sample_collector;

  localparam int D     = 12;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset, frame_valid, s_ready, rd_en;
  logic [15:0]   frame;
  logic [7:0]    ch_mask;
  logic [2:0]    rd_addr;
  logic          s_valid, s_valid8;
  logic [2:0]    s_channel, s_channel8;
  logic [D-1:0]  s_data, rd_data;
  logic [7:0]    s_data8, rd_data8;
  logic [7:0]    fresh, err_count, ovf_count, fresh8, err8, ovf8;

  always #5 clk = ~clk;

  ad79x8_sample_collector #(.DIGITS(D), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset), .frame_valid(frame_valid), .frame(frame),
    .ch_mask(ch_mask), .s_valid(s_valid), .s_ready(s_ready),
    .s_channel(s_channel), .s_data(s_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .fresh(fresh), .err_count(err_count), .ovf_count(ovf_count)
  );

  // 8-bit variant on the same stimulus, used for the field-extraction check
  ad79x8_sample_collector #(.DIGITS(8), .FIFO_DEPTH(DEPTH)) u_dut8 (
    .clk(clk), .reset(reset), .frame_valid(frame_valid), .frame(frame),
    .ch_mask(ch_mask), .s_valid(s_valid8), .s_ready(s_ready),
    .s_channel(s_channel8), .s_data(s_data8), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data8), .fresh(fresh8), .err_count(err8), .ovf_count(ovf8)
  );

  // Reference model
  logic [3+D-1:0] m_q[$];
  logic [D-1:0]   m_bank [8];
  logic [7:0]     m_fresh, m_err, m_ovf;
  logic [D-1:0]   m_rd, m_hdat;
  logic [2:0]     m_hch;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic fv, input logic [15:0] fr, input logic [7:0] mask,
                            input logic rdy, input logic re, input logic [2:0] ra,
                            input logic rst);
    logic [2:0]   ch;
    logic [D-1:0] d;
    if (rst) begin
      m_q.delete();
      for (int i = 0; i < 8; i++) m_bank[i] = '0;
      m_fresh = '0; m_err = '0; m_ovf = '0; m_rd = '0; m_hch = '0; m_hdat = '0;
      return;
    end
    if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
    if (re) begin
      m_rd = m_bank[ra];
      m_fresh[ra] = 1'b0;
    end
    if (fv) begin
      if (fr[15]) begin
        if (m_err < 8'd255) m_err++;
      end else begin
        ch = fr[14:12];
        d  = fr[11 -: D];
        m_bank[ch]  = d;
        m_fresh[ch] = 1'b1;
        if (mask[ch]) begin
          if (m_q.size() < DEPTH) m_q.push_back({ch, d});
          else if (m_ovf < 8'd255) m_ovf++;
        end
      end
    end
    if (m_q.size() > 0) {m_hch, m_hdat} = m_q[0];
  endtask

  // One clock: drive on negedge, advance model, check just after posedge
  task automatic cyc(input logic fv, input logic [15:0] fr, input logic [7:0] mask,
                     input logic rdy, input logic re, input logic [2:0] ra,
                     input logic rst);
    @(negedge clk);
    reset = rst; frame_valid = fv; frame = fr; ch_mask = mask;
    s_ready = rdy; rd_en = re; rd_addr = ra;
    model_step(fv, fr, mask, rdy, re, ra, rst);
    @(posedge clk);
    #1;
    chk("s_valid",   s_valid,   (m_q.size() != 0));
    chk("s_channel", s_channel, m_hch);
    chk("s_data",    s_data,    m_hdat);
    chk("rd_data",   rd_data,   m_rd);
    chk("fresh",     fresh,     m_fresh);
    chk("err_count", err_count, m_err);
    chk("ovf_count", ovf_count, m_ovf);
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 16'h0, 8'hFF, rdy, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]   fsave;
    logic [D-1:0] old5;
    int           nval;

    reset = 1'b1; frame_valid = 1'b0; frame = '0; ch_mask = 8'hFF;
    s_ready = 1'b0; rd_en = 1'b0; rd_addr = '0;

    cyc(1'b0, 16'h0, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b1);
    cyc(1'b0, 16'h0, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b1);
    chk("rst_valid", s_valid, 1'b0);
    chk("rst_fresh", fresh, 8'h00);

    // Basic frame then bank read
    cyc(1'b1, 16'h3A50, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("basic_valid", s_valid, 1'b1);
    chk("basic_ch",    s_channel, 3'd3);
    chk("basic_data",  s_data, 12'hA50);
    chk("basic_fresh", fresh, 8'h08);
    cyc(1'b0, 16'h0, 8'hFF, 1'b1, 1'b1, 3'd3, 1'b0);
    chk("rd_data3",    rd_data, 12'hA50);
    chk("rd_fresh",    fresh, 8'h00);

    // Resolution-dependent extraction
    cyc(1'b1, 16'h7ABC, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("d8_ch",   s_channel8, 3'd7);
    chk("d8_data", s_data8, 8'hAB);
    chk("d12_data", s_data, 12'hABC);
    idle(1'b1);

    // Framing error
    fsave = fresh;
    cyc(1'b1, 16'h8123, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("err_inc",   err_count, 8'd1);
    chk("err_fresh", fresh, fsave);
    chk("err_valid", s_valid, 1'b0);

    // Overflow: DEPTH+3 pushes with no consumer
    for (int i = 0; i < DEPTH + 3; i++)
      cyc(1'b1, {1'b0, 3'(i % 8), 12'($urandom)}, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("ovf_cnt", ovf_count, 8'd3);
    nval = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (s_valid) nval++;
      idle(1'b1);
    end
    chk("drain_cnt",   nval, DEPTH);
    chk("drain_empty", s_valid, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 16'h0, 8'hFF, 1'b0, 1'b1, 3'(i), 1'b0);

    // Full with simultaneous pop and push
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, {1'b0, 3'(i % 8), 12'($urandom)}, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1'b1, {1'b0, 3'd6, 12'h6C6}, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0);
    chk("fullpop_ovf", ovf_count, 8'd3);
    nval = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (s_valid) nval++;
      idle(1'b1);
    end
    chk("fullpop_occ", nval, DEPTH);

    // Channel mask and read/write collision
    for (int i = 0; i < 8; i++) cyc(1'b0, 16'h0, 8'h01, 1'b1, 1'b1, 3'(i), 1'b0);
    cyc(1'b1, {1'b0, 3'd0, 12'h111}, 8'h01, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1'b1, {1'b0, 3'd5, 12'h555}, 8'h01, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("mask_fresh", fresh, 8'h21);
    chk("mask_head",  s_channel, 3'd0);
    old5 = 12'h555;
    cyc(1'b1, {1'b0, 3'd5, 12'h5AA}, 8'h01, 1'b0, 1'b1, 3'd5, 1'b0);
    chk("coll_rd",    rd_data, old5);
    chk("coll_fresh", fresh[5], 1'b1);
    idle(1'b1);
    chk("mask_only0", s_valid, 1'b0);

    // Reset with 4 entries and a concurrent frame
    for (int i = 0; i < 4; i++)
      cyc(1'b1, {1'b0, 3'(i), 12'($urandom)}, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1'b1, {1'b0, 3'd2, 12'h222}, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b1);
    chk("mrst_valid", s_valid, 1'b0);
    chk("mrst_err",   err_count, 8'd0);
    chk("mrst_ovf",   ovf_count, 8'd0);
    idle(1'b0);
    chk("mrst_fresh", fresh, 8'h00);
    chk("mrst_empty", s_valid, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] fr;
      fr = 16'($urandom);
      fr[15] = ($urandom_range(7) == 0);
      cyc(($urandom_range(9) < 6), fr, 8'($urandom), ($urandom_range(1) == 1),
          ($urandom_range(3) == 0), 3'($urandom), ($urandom_range(299) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ad79x8_sample_collector.md
# ad79x8_sample_collector

Downstream stage of the AD79X8 SPI master. It takes each 16-bit conversion frame the master shifts in from the AD7908/AD7918/AD7928, checks the frame and extracts the channel address and result bits. It then keeps the latest sample of every channel in a register bank and forwards every accepted sample through a first-word-fall-through FIFO with a valid/ready handshake. The master cannot stall, so the collector never back-pressures it: excess samples are dropped and counted.

## Interface
Parameters:
- DIGITS, 8: converter resolution; legal values are 8 (AD7908), 10 (AD7918) and 12 (AD7928).
- FIFO_DEPTH, 8: sample FIFO entries; must be a power of two and at least 2.

Ports:
- clk  in  1  system clock; everything is sampled on the rising edge.
- reset  in  1  reset, synchronous, active-high; clock clk.
- frame_valid  in  1  one-cycle strobe from the SPI master: frame holds a completed word.
- frame  in  16  received word: bit15 is the leading zero, bits14:12 are ADD2..0, bits11:0 are the result MSB-first.
- ch_mask  in  8  bit n = 1 enables FIFO forwarding of channel n; the bank is updated regardless.
- s_valid  out  1  FIFO head is valid.
- s_ready  in  1  consumer accepts the head.
- s_channel  out  3  channel of the FIFO head.
- s_data  out  DIGITS  sample of the FIFO head.
- rd_en  in  1  bank read strobe.
- rd_addr  in  3  bank channel to read.
- rd_data  out  DIGITS  registered bank value.
- fresh  out  8  bit n = 1 means channel n was written since its last read.
- err_count  out  8  saturating count of framing errors.
- ovf_count  out  8  saturating count of dropped samples.

## Operation
- Field extraction: data = frame[11 : 12-DIGITS]. For DIGITS < 12, the low 12-DIGITS bits are ignored, not checked.
- Framing check: if frame_valid and frame[15] = 1:
  - drop the frame entirely (no bank write, no FIFO push);
  - increment err_count, saturating at 255.
- Good frame:
  - write bank[ch] with data and set fresh[ch];
  - if ch_mask[ch] = 1, push {ch, data} into the FIFO.
- FIFO push rules:
  - If the FIFO is full and no pop happens that cycle, the push is dropped and ovf_count increments, saturating at 255. The bank is still written.
  - Full with a simultaneous pop: the push is accepted, the count is unchanged and ovf_count is unchanged.
- Pop: happens when s_valid and s_ready are both 1. s_valid, s_channel and s_data come straight from the head entry (FWFT). s_channel and s_data hold their last value when s_valid = 0.
- Bank read: rd_en loads rd_data with bank[rd_addr] and clears fresh[rd_addr].
  - rd_en and a good frame hit the same channel in the same cycle: rd_data gets the pre-update value, and fresh stays 1 because the set wins.
  - rd_en on a different channel than the frame: both actions take effect.
- FIFO storage: pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. An occupancy counter with range 0..FIFO_DEPTH separates full from empty.
- Reset values:
  - bank cleared to all zero;
  - fresh, err_count, ovf_count, rd_data, s_channel and s_data all 0;
  - s_valid = 0;
  - FIFO emptied and pointers set to 0.
- Reset mid-operation: a frame_valid in the reset cycle is ignored. Any FIFO contents are discarded and no handshake completes in that cycle.

## Timing
- Frame accepted at edge N:
  - bank, fresh and counters are updated at edge N; the new values are visible after N.
  - If the FIFO was empty, s_valid rises after edge N, so the sample is available one cycle after frame_valid.
- Pop at edge N: the next entry appears after N, so back-to-back pops sustain one sample per cycle.
- rd_en at edge N: rd_data is valid after N (one cycle of latency).
- frame_valid may assert on consecutive cycles; every cycle is processed independently.
- Counters hold at 255 and are cleared only by reset.

## Test plan
- Reset, then a good frame 0x3A50 with DIGITS=12 and ch_mask=0xFF: one cycle later, s_valid=1, s_channel=3, s_data=0xA50, fresh=0x08. A following rd_en with rd_addr=3 gives rd_data=0xA50 and fresh=0x00.
- DIGITS=8, frame 0x7ABC: s_channel=7 and s_data=0xAB; bits 3:0 are ignored.
- Frame 0x8123 (bit15 set): err_count goes 0 -> 1, no bank write, fresh unchanged, s_valid stays 0.
- With s_ready=0, push FIFO_DEPTH+3 good frames: FIFO holds the first 8, ovf_count=3, and every channel's bank holds its last value. Then hold s_ready=1: the 8 entries drain in order on 8 consecutive cycles.
- FIFO full while s_ready=1 and frame_valid arrive in the same cycle: the push is accepted, ovf_count stays unchanged and occupancy stays at FIFO_DEPTH.
- ch_mask=0x01 with frames on channels 0 and 5:
  - only channel 0 reaches the FIFO, while fresh=0x21;
  - rd_en on channel 5 in the same cycle as a new channel-5 frame returns the old value, and fresh[5] stays 1.
- Reset asserted while the FIFO holds 4 entries: s_valid=0, both counters are 0, and an accompanying frame_valid is ignored.
